pe_ctrl: RTL and testbench
==========================

# pe_ctrl

Per-PE micro-sequencer that sits directly upstream of the `pe` MAC element. It drives the PE's load, shift, multiply/add-gate, accumulator-clear and partial-sum controls for one dot product of `RFW = CHANNELS*KERNEL_SIZE` terms. It also gives the downstream result collector a valid/ready handshake on the finished 32-bit accumulator. One instance serves one PE, or a PE row driven in lock-step.

## Interface
- `CHANNELS`, 4, input channels per dot product
- `KERNEL_SIZE`, 3, kernel taps per channel; `RFW = CHANNELS*KERNEL_SIZE` (must be ≥ 2)
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  request one dot product; sampled only in IDLE or on a DONE handshake
- `wht_reload`  in  1  latched at start; 1 = stream new weights during LOAD
- `psum_en`  in  1  latched at start; 1 = add upstream psum after MAC
- `abort`  in  1  synchronous cancel; highest priority after reset
- `busy`  out  1  state ≠ IDLE
- `ld_idx`  out  $clog2(RFW)  element index being loaded (buffer read address); 0 outside LOAD
- `if_i_en`, `wht_i_en`, `reg_sft_en`, `mul_une`, `add_une`, `acc_rst`, `psum_sel`, `psum_i_en`, `psum_acc_start`  out  1 each  PE controls
- `res_valid`  out  1  PE `out` holds final sum
- `res_ready`  in  1  collector accepts result

## Operation
- States: IDLE, LOAD, MAC, DRAIN, PSUM, DONE. `step` counter counts 0..RFW-1 in LOAD and MAC.
- Reset and IDLE outputs: `mul_une=1`, `add_une=1`, all other outputs 0, `step=0`, `ld_idx=0`.
- IDLE: on `start` → LOAD, latch `wht_reload` and `psum_en`.
- LOAD (RFW cycles): `if_i_en=1`, `wht_i_en=wht_reload`, `ld_idx=step`, `mul_une=1`, `add_une=1`.
  - In the last LOAD cycle, `acc_rst=1` and `add_une=0`. The PE gives `add_une` priority over `acc_rst`, so this combination is needed to clear the accumulator.
- MAC (RFW cycles): `reg_sft_en=1`, `mul_une=0`.
  - `add_une=1` in step 0, because the product register is still stale.
  - `add_une=0` in steps 1..RFW-1.
  - A full rotation restores both register files, so weights stay resident when `wht_reload=0`.
- DRAIN (1 cycle): `mul_une=1`, `add_une=0`. This accumulates the last product.
- PSUM (1 cycle, only if latched `psum_en`): `psum_sel=1`, `psum_i_en=1`, `psum_acc_start=1`, `add_une=0`, `mul_une=1`. Otherwise DRAIN → DONE.
- DONE: `res_valid=1`, `add_une=1`, `mul_une=1`. The accumulator is held until handshake.
  - On `res_valid & res_ready`: if `start` → LOAD (back-to-back, latches new config); else → IDLE.
- `start` in any other state is ignored. It is not queued.
- `abort` in any state → IDLE next edge, with IDLE outputs. The PE accumulator is left as-is and is cleared by the next LOAD.
- Asynchronous reset mid-operation: immediate return to IDLE values. No result is produced.

## Timing
- Edge 0 samples `start`. LOAD spans after edges 0..RFW-1, MAC after RFW..2RFW-1, DRAIN after 2RFW, PSUM after 2RFW+1.
- `res_valid` rises after edge 2RFW+2 with psum, or 2RFW+1 without. For RFW=12 that is 26 or 25 cycles.
- Products are captured at edges RFW+1..2RFW and accumulated one edge later. The final sum (plus psum) is stable when `res_valid` rises.
- Throughput with `res_ready` tied 1 and `start` held: one result per 2RFW+3 cycles, or 2RFW+2 without psum.
- All outputs are registered or decoded from the state/step registers only. There is no combinational path from `res_ready` or `start` to PE controls.

## Configuration
- `PE_CTRL_PSUM_EN` defined: PSUM state and `psum_en` behave as above.
- Not defined: PSUM state is not built; `psum_en` is ignored. `psum_sel`, `psum_i_en` and `psum_acc_start` are constant 0, and latency is always 2RFW+1.

## Structure
- Shared package `pe_pkg`: state enum (IDLE, LOAD, MAC, DRAIN, PSUM, DONE), default `CHANNELS`/`KERNEL_SIZE`, `RFW` derivation, step-counter width function.
- No sub-module. State register, step counter and output decode stay in one module.

## Test plan
- RFW=12, `wht_reload=1`, `psum_en=1`, `res_ready=1`; PE fed if=1..12, wht=2, psum=100 → `res_valid` after edge 26; PE out = 2·78+100 = 256.
- Same data, `psum_en=0`, then a second start with `wht_reload=0` and if=1 → results 156, then 24. `wht_i_en` is never high in the second LOAD.
- `res_ready` held 0 for 10 cycles in DONE → `res_valid` and PE out stay constant at 256. A `start` pulse during MAC is ignored.
- DONE with `res_ready=1` and `start=1` → LOAD on the next edge, with no IDLE cycle and `acc_rst` in its last cycle.
- `abort` in MAC step 5 → IDLE next edge with IDLE output values. A fresh start then yields the correct sum 156.
- `rst_n` low mid-LOAD → all outputs at reset values asynchronously. Build without `PE_CTRL_PSUM_EN` → the psum outputs stay 0 and `res_valid` comes after edge 25.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the PE micro-sequencer: state encoding, default
// geometry, register-file width derivation and the PE control bundle.
package pe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    DRAIN,
    PSUM,
    DONE
  } pe_state_t;

  localparam int unsigned DEF_CHANNELS    = 4;
  localparam int unsigned DEF_KERNEL_SIZE = 3;

  // Register-file depth: one entry per term of the dot product.
  function automatic int unsigned rfw(input int unsigned channels,
                                      input int unsigned kernel_size);
    return channels * kernel_size;
  endfunction

  // Width of the step counter / load index; never narrower than one bit.
  function automatic int unsigned step_width(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Single-bit PE controls, registered together as one bundle.
  typedef struct packed {
    logic if_i_en;
    logic wht_i_en;
    logic reg_sft_en;
    logic mul_une;
    logic add_une;
    logic acc_rst;
    logic psum_sel;
    logic psum_i_en;
    logic psum_acc_start;
    logic res_valid;
  } pe_ctrl_t;

  // Idle/reset values: multiplier and adder gated, everything else off.
  localparam pe_ctrl_t CTRL_IDLE = '{mul_une: 1'b1, add_une: 1'b1, default: 1'b0};

endpackage

// File: rtl/pe_ctrl.sv
// Per-PE micro-sequencer: loads the register files, runs RFW MAC cycles,
// drains the last product, optionally folds in an upstream partial sum and
// then hands the accumulator to the result collector via valid/ready.
// Optional feature macro: PE_CTRL_PSUM_EN (builds the PSUM state).
// All outputs are registered from the next-state/next-step decode, so
// neither start nor res_ready reaches a PE control combinationally.
module pe_ctrl
  import pe_pkg::*;
#(
  parameter int unsigned CHANNELS    = DEF_CHANNELS,
  parameter int unsigned KERNEL_SIZE = DEF_KERNEL_SIZE,
  localparam int unsigned RFW = rfw(CHANNELS, KERNEL_SIZE),
  localparam int unsigned SW  = step_width(RFW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          wht_reload,
  input  logic          psum_en,
  input  logic          abort,
  output logic          busy,
  output logic [SW-1:0] ld_idx,
  output logic          if_i_en,
  output logic          wht_i_en,
  output logic          reg_sft_en,
  output logic          mul_une,
  output logic          add_une,
  output logic          acc_rst,
  output logic          psum_sel,
  output logic          psum_i_en,
  output logic          psum_acc_start,
  output logic          res_valid,
  input  logic          res_ready
);

  localparam logic [SW-1:0] LAST_STEP = SW'(RFW - 1);

  pe_state_t     state, state_n;
  logic [SW-1:0] step, step_n;
  logic          reload_q, reload_n;
  logic          psum_q, psum_n;
  pe_ctrl_t      ctrl_q, ctrl_n;
  logic [SW-1:0] ld_idx_n;

`ifndef PE_CTRL_PSUM_EN
  logic unused_psum_en;
  assign unused_psum_en = psum_en;
`endif

  // Next state, step counter and latched per-run configuration.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_n  = state;
    step_n   = step;
    reload_n = reload_q;
    psum_n   = psum_q;
    if (abort) begin
      state_n = IDLE;
      step_n  = '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_n  = LOAD;
          step_n   = '0;
          reload_n = wht_reload;
          psum_n   = psum_en;
        end
        LOAD: if (step == LAST_STEP) begin
          state_n = MAC;
          step_n  = '0;
        end else begin
          step_n = step + 1'b1;
        end
        MAC: if (step == LAST_STEP) begin
          state_n = DRAIN;
          step_n  = '0;
        end else begin
          step_n = step + 1'b1;
        end
`ifdef PE_CTRL_PSUM_EN
        DRAIN: state_n = psum_q ? PSUM : DONE;
        PSUM:  state_n = DONE;
`else
        DRAIN: state_n = DONE;
`endif
        DONE: if (res_ready) begin
          if (start) begin
            state_n  = LOAD;
            step_n   = '0;
            reload_n = wht_reload;
            psum_n   = psum_en;
          end else begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          step_n  = '0;
        end
      endcase
    end
  end

  // Control decode for the cycle that follows the next edge.
  always_comb begin
    ctrl_n   = CTRL_IDLE;
    ld_idx_n = '0;
    case (state_n)
      LOAD: begin
        ctrl_n.if_i_en  = 1'b1;
        ctrl_n.wht_i_en = reload_n;
        ld_idx_n        = step_n;
        // The PE lets add_une override acc_rst, so the adder is ungated to clear.
        if (step_n == LAST_STEP) begin
          ctrl_n.acc_rst = 1'b1;
          ctrl_n.add_une = 1'b0;
        end
      end
      MAC: begin
        ctrl_n.reg_sft_en = 1'b1;
        ctrl_n.mul_une    = 1'b0;
        // Step 0 would accumulate the stale product register.
        ctrl_n.add_une    = (step_n == '0);
      end
      DRAIN: ctrl_n.add_une = 1'b0;
`ifdef PE_CTRL_PSUM_EN
      PSUM: begin
        ctrl_n.psum_sel       = 1'b1;
        ctrl_n.psum_i_en      = 1'b1;
        ctrl_n.psum_acc_start = 1'b1;
        ctrl_n.add_une        = 1'b0;
      end
`endif
      DONE: ctrl_n.res_valid = 1'b1;
      default: ctrl_n = CTRL_IDLE;
    endcase
  end

  // State, counter, configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      step     <= '0;
      reload_q <= 1'b0;
      psum_q   <= 1'b0;
      ctrl_q   <= CTRL_IDLE;
      ld_idx   <= '0;
      busy     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_n;
      step     <= step_n;
      reload_q <= reload_n;
      psum_q   <= psum_n;
      ctrl_q   <= ctrl_n;
      ld_idx   <= ld_idx_n;
      busy     <= (state_n != IDLE);
    end
  end

  assign if_i_en        = ctrl_q.if_i_en;
  assign wht_i_en       = ctrl_q.wht_i_en;
  assign reg_sft_en     = ctrl_q.reg_sft_en;
  assign mul_une        = ctrl_q.mul_une;
  assign add_une        = ctrl_q.add_une;
  assign acc_rst        = ctrl_q.acc_rst;
  assign psum_sel       = ctrl_q.psum_sel;
  assign psum_i_en      = ctrl_q.psum_i_en;
  assign psum_acc_start = ctrl_q.psum_acc_start;
  assign res_valid      = ctrl_q.res_valid;

endmodule

// File: tb/tb_pe_ctrl.sv
// Bench for pe_ctrl: a behavioural PE driven by the sequencer's controls
// produces the dot product, compared with plain arithmetic; every cycle the
// control word is compared with a timeline derived from the cycle count.
module tb_pe_ctrl;

  localparam int RFW = 12;
  localparam int IW  = 4;
`ifdef PE_CTRL_PSUM_EN
  localparam bit PS_BUILT = 1'b1;
`else
  localparam bit PS_BUILT = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, wht_reload = 1'b0, psum_en = 1'b0, abort = 1'b0, res_ready = 1'b0;
  logic busy, if_i_en, wht_i_en, reg_sft_en, mul_une, add_une, acc_rst;
  logic psum_sel, psum_i_en, psum_acc_start, res_valid;
  logic [IW-1:0] ld_idx;

  int tests = 0;
  int fails = 0;

  pe_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wht_reload(wht_reload),
    .psum_en(psum_en), .abort(abort), .busy(busy), .ld_idx(ld_idx),
    .if_i_en(if_i_en), .wht_i_en(wht_i_en), .reg_sft_en(reg_sft_en),
    .mul_une(mul_une), .add_une(add_une), .acc_rst(acc_rst),
    .psum_sel(psum_sel), .psum_i_en(psum_i_en), .psum_acc_start(psum_acc_start),
    .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  logic [14:0] ctrl;
  assign ctrl = {busy, ld_idx, if_i_en, wht_i_en, reg_sft_en, mul_une, add_une,
                 acc_rst, psum_sel, psum_i_en, psum_acc_start, res_valid};

  // Behavioural PE: operand buffers, rotating register files, product and accumulator.
  logic [7:0]  if_mem [RFW];
  logic [7:0]  w_mem  [RFW];
  logic [7:0]  w_res  [RFW];
  logic [31:0] psum_in = 32'd0;
  logic [7:0]  rf_if  [RFW];
  logic [7:0]  rf_w   [RFW];
  logic [31:0] prod, acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RFW; i++) begin
        rf_if[i] <= 8'd0;
        rf_w[i]  <= 8'd0;
      end
      prod <= 32'd0;
      acc  <= 32'd0;
    end else begin
      if (if_i_en)  rf_if[ld_idx] <= if_mem[ld_idx];
      if (wht_i_en) rf_w[ld_idx]  <= w_mem[ld_idx];
      if (reg_sft_en)
        for (int i = 0; i < RFW; i++) begin
          rf_if[i] <= rf_if[(i + 1) % RFW];
          rf_w[i]  <= rf_w[(i + 1) % RFW];
        end
      if (!mul_une) prod <= 32'(rf_if[0]) * 32'(rf_w[0]);
      if (!add_une) acc <= acc_rst ? 32'd0 : acc + (psum_sel ? psum_in : prod);
    end
  end

  // Expected control word k cycles after the start edge; k < 0 means idle.
  function automatic logic [14:0] exp_ctrl(input int k, input bit rl, input bit pe);
    logic b, ie, we, sf, mu, au, ar, ps, pi, pa, rv;
    logic [IW-1:0] li;
    b = 1; li = '0; ie = 0; we = 0; sf = 0; mu = 1; au = 1; ar = 0; ps = 0; pi = 0; pa = 0; rv = 0;
    if (k < 0) b = 0;
    else if (k < RFW) begin
      li = IW'(k); ie = 1; we = rl;
      au = (k != RFW - 1); ar = (k == RFW - 1);
    end else if (k < 2 * RFW) begin
      sf = 1; mu = 0; au = (k == RFW);
    end else if (k == 2 * RFW) au = 0;
    else if (pe && k == 2 * RFW + 1) begin
      ps = 1; pi = 1; pa = 1; au = 0;
    end else rv = 1;
    return {b, li, ie, we, sf, mu, au, ar, ps, pi, pa, rv};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic fill(input bit ramp, input bit ones, input logic [7:0] w_const, input bit rnd_w);
    for (int i = 0; i < RFW; i++) begin
      if_mem[i] = ramp ? 8'(i + 1) : (ones ? 8'd1 : 8'($urandom));
      w_mem[i]  = rnd_w ? 8'($urandom) : w_const;
    end
  endtask

  // One dot product; entered at a negedge in IDLE or DONE, leaves in DONE.
  task automatic run_op(input bit rl, input bit ps, input int hold, input bit poke_start);
    bit pe;
    int lat;
    logic [31:0] exp_sum;
    pe  = ps & PS_BUILT;
    lat = 2 * RFW + 1 + int'(pe);
    if (rl) for (int i = 0; i < RFW; i++) w_res[i] = w_mem[i];
    exp_sum = pe ? psum_in : 32'd0;
    for (int i = 0; i < RFW; i++) exp_sum += 32'(if_mem[i]) * 32'(w_res[i]);
    start = 1; wht_reload = rl; psum_en = ps; res_ready = 1;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      start     = poke_start && (k == RFW + 3);
      res_ready = 0;
      check($sformatf("ctrl_k%0d", k), 32'(ctrl), 32'(exp_ctrl(k, rl, pe)));
    end
    check("sum", acc, exp_sum);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_ctrl", 32'(ctrl), 32'(exp_ctrl(lat, rl, pe)));
      check("hold_sum", acc, exp_sum);
    end
  endtask

  task automatic finish_idle();
    res_ready = 1; start = 0;
    @(negedge clk);
    check("to_idle", 32'(ctrl), 32'(exp_ctrl(-1, 0, 0)));
    res_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit chain;
    repeat (2) @(negedge clk);
    check("reset_vals", 32'(ctrl), 32'(exp_ctrl(-1, 0, 0)));
    rst_n = 1;
    @(negedge clk);
    check("idle_vals", 32'(ctrl), 32'(exp_ctrl(-1, 0, 0)));

    // Ramp 1..12 with weight 2 and psum 100; hold result, ignore start in MAC.
    fill(1, 0, 8'd2, 0); psum_in = 32'd100;
    run_op(1, 1, 10, 1);
    finish_idle();

    // No psum, then back-to-back with resident weights and all-ones input.
    run_op(1, 0, 0, 0);
    fill(0, 1, 8'd0, 1);
    run_op(0, 0, 0, 0);
    finish_idle();

    // Random configurations and data, some chained through DONE.
    for (int n = 0; n < 6; n++) begin
      bit rl;
      rl = (n == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
      fill(0, 0, 8'd0, 1);
      psum_in = $urandom;
      run_op(rl, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
      chain = 1'($urandom_range(0, 1));
      if (!chain || n == 5) finish_idle();
    end

    // Abort in MAC step 5, then a clean run.
    fill(1, 0, 8'd2, 0);
    start = 1; wht_reload = 1; psum_en = 0; res_ready = 1;
    for (int k = 0; k <= RFW + 5; k++) begin
      @(negedge clk);
      start = 0; res_ready = 0;
    end
    check("pre_abort", 32'(ctrl), 32'(exp_ctrl(RFW + 5, 1, 0)));
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("abort_idle", 32'(ctrl), 32'(exp_ctrl(-1, 0, 0)));
    run_op(1, 0, 0, 0);
    finish_idle();

    // Asynchronous reset in the middle of LOAD.
    start = 1; wht_reload = 1; psum_en = 1;
    repeat (5) begin
      @(negedge clk);
      start = 0;
    end
    #2 rst_n = 0;
    #1 check("async_reset", 32'(ctrl), 32'(exp_ctrl(-1, 0, 0)));
    @(negedge clk);
    rst_n = 1;
    fill(0, 0, 8'd0, 1);
    psum_in = $urandom;
    run_op(1, 1, 1, 0);
    finish_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
